// File: rtl/linear_output_collector.sv
// Captures multiplier output vectors into a FIFO and serialises them onto a valid/ready stream.
// Optional overflow detection is enabled by defining LINEAR_OUTPUT_COLLECTOR_OVF_EN.
module linear_output_collector #(
  parameter int PRECISION    = 8,
  parameter int NUM_FEATURES = 2,
  parameter int PIPE_LATENCY = 6,
  parameter int FIFO_DEPTH   = 16,
  parameter int ROW_LEN      = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue,
  output logic                              ce,
  input  logic [PRECISION*NUM_FEATURES-1:0] out_vec,
  output logic [PRECISION-1:0]              m_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic                              m_last,
  output logic                              ovf
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int RW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  typedef logic [PRECISION*NUM_FEATURES-1:0] vec_t;

  logic [PIPE_LATENCY-1:0] vld_sr;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           inflight;
  logic [CW:0]             credit_sum;
  vec_t                    mem [FIFO_DEPTH];
  vec_t                    head;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           lane_idx;
  logic [RW-1:0]           row_cnt;
  logic                    capture;
  logic                    push;
  logic                    pop;
  logic                    lane_last;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int k = 0; k < PIPE_LATENCY; k++) begin
      inflight = inflight + CW'(vld_sr[k]);
    end
  end

  // Credit covers both queued vectors and those still travelling through the multiplier.
  assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight};
  assign ce         = rst && (credit_sum < (CW + 1)'(FIFO_DEPTH));

  assign m_valid   = (fifo_count != '0);
  assign lane_last = (lane_idx == LW'(NUM_FEATURES - 1));
  assign pop       = m_valid && m_ready && lane_last;
  assign capture   = ce && vld_sr[PIPE_LATENCY-1];
  assign m_last    = m_valid && lane_last && (row_cnt == RW'(ROW_LEN - 1));
  assign head      = mem[rd_ptr];

  always_comb begin
    m_data = '0;
    for (int l = 0; l < NUM_FEATURES; l++) begin
      if (m_valid && (lane_idx == LW'(l))) begin
        m_data = head[l*PRECISION +: PRECISION];
      end
    end
  end

`ifdef LINEAR_OUTPUT_COLLECTOR_OVF_EN
  logic full;
  logic ovf_q;

  assign full = (fifo_count == CW'(FIFO_DEPTH));
  // A capture into a full FIFO without a same-cycle pop is dropped and latched as overflow.
  assign push = capture && (!full || pop);
  assign ovf  = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (capture && full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

  property p_no_overflow;
    @(posedge clk) disable iff (!rst) !(capture && full && !pop);
  endproperty
  a_no_overflow: assert property (p_no_overflow)
    else $warning("linear_output_collector: capture into full FIFO, vector dropped");
`else
  assign push = capture;
  assign ovf  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      lane_idx   <= '0;
      row_cnt    <= '0;
    end else begin
      if (ce) begin
        vld_sr <= {vld_sr[PIPE_LATENCY-2:0], issue};
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (m_valid && m_ready) begin
        if (lane_last) begin
          lane_idx <= '0;
          row_cnt  <= (row_cnt == RW'(ROW_LEN - 1)) ? '0 : row_cnt + RW'(1);
        end else begin
          lane_idx <= lane_idx + LW'(1);
        end
      end
    end
  end

  // Storage is deliberately unreset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= out_vec;
    end
  end

endmodule
